// File: rtl/vdp1_cmd_list_writer_pkg.sv
// vdp1_cmd_list_writer_pkg: command-table layout, per-word write masks and list-writer FSM states
package vdp1_cmd_list_writer_pkg;

  typedef logic [255:0] cmdtbl_t;

  typedef enum logic [1:0] {LW_IDLE, LW_WRITE, LW_TERM} list_wr_state_t;

  localparam logic [15:0] CMD_END_WORD    = 16'h8000;
  localparam logic [15:0] CTRL_WRITE_MASK = 16'h0F3F;
  localparam logic [3:0]  LAST_IDX        = 4'd14;

  // Word 0 sits in the top 16 bits, same ordering as cmdtbl_t
  localparam logic [255:0] CMDWORD_MASK = {
    CTRL_WRITE_MASK, 16'hFFFC, 16'h9FFF, 16'hFFFF, 16'hFFFC, 16'h3FFF, {10{16'hFFFF}}
  };

  function automatic logic [15:0] cmd_word(input cmdtbl_t c, input logic [3:0] idx);
    return c[{~idx, 4'hF} -: 16] & CMDWORD_MASK[{~idx, 4'hF} -: 16];
  endfunction

endpackage

// File: rtl/vdp1_cmd_list_writer.sv
// vdp1_cmd_list_writer: serializes command tables into VRAM as a jump-next list closed by an END word
module vdp1_cmd_list_writer
  import vdp1_cmd_list_writer_pkg::*;
#(
  parameter logic [15:0] BASE_LINK = 16'h0000,
  parameter logic [15:0] MAX_CMDS  = 16'd1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  cmdtbl_t       cmd_data,
  input  logic          list_start,
  input  logic          list_close,
  output logic [17:0]   vram_a,
  output logic [15:0]   vram_d,
  output logic          vram_we,
  input  logic          vram_ack,
  output logic          busy,
  output logic          done,
  output logic [15:0]   count,
  output logic          ovf
);

  list_wr_state_t state, state_n;
  cmdtbl_t        cmd_q;
  logic [3:0]     idx;
  logic [15:0]    slot;
  logic           pend_start, pend_close;
  logic           idle, acked, last, go_start, go_close, accept;
  logic [17:0]    slot_addr;

  always_comb begin
    idle      = state == LW_IDLE;
    acked     = vram_we & vram_ack;
    last      = idx == LAST_IDX;
    go_start  = idle & (list_start | pend_start);
    go_close  = idle & ~go_start & (list_close | pend_close);
    // A same-cycle start/close pulse wins over the command, so the handshake is withheld
    cmd_ready = idle & ~ovf & ~pend_start & ~pend_close & ~list_start & ~list_close;
    accept    = ce & cmd_valid & cmd_ready;
    slot_addr = {BASE_LINK, 2'b00} + {slot[13:0], 4'h0};
    busy      = ~idle;
    state_n   = idle ? (go_close ? LW_TERM : accept ? LW_WRITE : LW_IDLE)
              : (acked & (state == LW_TERM | last)) ? LW_IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LW_IDLE;
      cmd_q      <= '0;
      idx        <= '0;
      slot       <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      pend_start <= 1'b0;
      pend_close <= 1'b0;
      vram_we    <= 1'b0;
      vram_a     <= '0;
      vram_d     <= '0;
      done       <= 1'b0;
    end else if (ce) begin
      state      <= state_n;
      done       <= 1'b0;
      pend_start <= idle ? 1'b0 : pend_start | list_start;
      // A start discards any close latched before it, but keeps one arriving with it
      pend_close <= list_start ? list_close : go_close ? 1'b0 : pend_close | list_close;
      if (go_start) begin
        slot  <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end
      if (accept) begin
        cmd_q   <= cmd_data;
        idx     <= '0;
        vram_we <= 1'b1;
        vram_a  <= slot_addr;
        vram_d  <= cmd_word(cmd_data, 4'd0);
      end
      if (go_close) begin
        vram_we <= 1'b1;
        vram_a  <= slot_addr;
        vram_d  <= CMD_END_WORD;
      end
      if (state == LW_WRITE) begin
        if (acked) begin
          vram_we <= 1'b0;
          if (last) begin
            slot  <= slot + 16'd1;
            count <= count + 16'd1;
            ovf   <= (count + 16'd1) == (MAX_CMDS - 16'd1);
          end else begin
            idx <= idx + 4'd1;
          end
        end else if (!vram_we) begin
          vram_we <= 1'b1;
          vram_a  <= slot_addr + 18'(idx);
          vram_d  <= cmd_word(cmd_q, idx);
        end
      end
      if (state == LW_TERM && acked) begin
        vram_we <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vdp1_cmd_list_writer.sv
// tb_vdp1_cmd_list_writer: three differently parameterised writers, one selected at a time,
// checked against a write-list model and hand-computed literals
module tb_vdp1_cmd_list_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b1;
  logic         ce_toggle = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [255:0] cmd_data = '0;
  logic         list_start = 1'b0;
  logic         list_close = 1'b0;
  logic         ack = 1'b1;
  int           sel = 0;

  logic        ready_o[3], we_o[3], busy_o[3], done_o[3], ovf_o[3];
  logic [17:0] a_o[3];
  logic [15:0] d_o[3], count_o[3];

  logic        s_ready, s_we, s_busy, s_done, s_ovf;
  logic [17:0] s_a;
  logic [15:0] s_d, s_count;

  assign s_ready = ready_o[sel];
  assign s_we    = we_o[sel];
  assign s_busy  = busy_o[sel];
  assign s_done  = done_o[sel];
  assign s_ovf   = ovf_o[sel];
  assign s_a     = a_o[sel];
  assign s_d     = d_o[sel];
  assign s_count = count_o[sel];

  vdp1_cmd_list_writer #(.BASE_LINK(16'h0000), .MAX_CMDS(16'd1024)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cmd_valid(cmd_valid && sel == 0), .cmd_ready(ready_o[0]),
    .cmd_data(cmd_data), .list_start(list_start && sel == 0), .list_close(list_close && sel == 0),
    .vram_a(a_o[0]), .vram_d(d_o[0]), .vram_we(we_o[0]), .vram_ack(ack),
    .busy(busy_o[0]), .done(done_o[0]), .count(count_o[0]), .ovf(ovf_o[0]));

  vdp1_cmd_list_writer #(.BASE_LINK(16'h0100), .MAX_CMDS(16'd1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cmd_valid(cmd_valid && sel == 1), .cmd_ready(ready_o[1]),
    .cmd_data(cmd_data), .list_start(list_start && sel == 1), .list_close(list_close && sel == 1),
    .vram_a(a_o[1]), .vram_d(d_o[1]), .vram_we(we_o[1]), .vram_ack(ack),
    .busy(busy_o[1]), .done(done_o[1]), .count(count_o[1]), .ovf(ovf_o[1]));

  vdp1_cmd_list_writer #(.BASE_LINK(16'h0000), .MAX_CMDS(16'd2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cmd_valid(cmd_valid && sel == 2), .cmd_ready(ready_o[2]),
    .cmd_data(cmd_data), .list_start(list_start && sel == 2), .list_close(list_close && sel == 2),
    .vram_a(a_o[2]), .vram_d(d_o[2]), .vram_we(we_o[2]), .vram_ack(ack),
    .busy(busy_o[2]), .done(done_o[2]), .count(count_o[2]), .ovf(ovf_o[2]));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    ce = ce_toggle ? ~ce : 1'b1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: per-instance slot pointer and count, plus the ordered list of writes VRAM must see
  int          base_of[3] = '{0, 256, 0};
  int          max_of[3]  = '{1024, 1024, 2};
  int          mslot[3]   = '{0, 0, 0};
  int          mcount[3]  = '{0, 0, 0};
  logic [33:0] exp_q[$];

  function automatic logic [15:0] exp_word(input logic [255:0] c, input int i);
    logic [255:0] s;
    logic [15:0]  w;
    s = c << (16 * i);
    w = s[255:240];
    case (i)
      0:       return w & 16'h0F3F;
      1, 4:    return w & 16'hFFFC;
      2:       return w & 16'h9FFF;
      5:       return w & 16'h3FFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [17:0] slot_word_addr(input int inst, input int i);
    int a;
    a = (base_of[inst] * 4 + mslot[inst] * 16 + i) & 32'h3FFFF;
    return a[17:0];
  endfunction

  task automatic m_cmd(input logic [255:0] c);
    for (int i = 0; i < 15; i++) exp_q.push_back({slot_word_addr(sel, i), exp_word(c, i)});
    mslot[sel]++;
    mcount[sel]++;
  endtask

  // Monitor: every acknowledged write must match the model's next entry; a pending write must hold
  logic [17:0] log_a[256];
  logic [15:0] log_d[256];
  int          n = 0;
  int          done_cnt = 0;

  initial begin
    logic        prev_hold;
    logic [17:0] pa;
    logic [15:0] pd;
    logic [33:0] e;
    prev_hold = 1'b0;
    pa = '0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_we", {31'd0, s_we}, 32'd1);
          chk("hold_a", {14'd0, s_a}, {14'd0, pa});
          chk("hold_d", {16'd0, s_d}, {16'd0, pd});
        end
        if (ce && s_we && ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write_a", {14'd0, s_a}, 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("write_a", {14'd0, s_a}, {14'd0, e[33:16]});
            chk("write_d", {16'd0, s_d}, {16'd0, e[15:0]});
          end
          if (n < 256) begin
            log_a[n] = s_a;
            log_d[n] = s_d;
          end
          n++;
        end
        if (s_done) done_cnt++;
        prev_hold = s_we && !(ce && ack);
        pa = s_a;
        pd = s_d;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [255:0] c);
    cmd_data  = c;
    cmd_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready && ce) begin
        m_cmd(c);
        tick();
        cmd_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse(input bit is_start);
    if (is_start) list_start = 1'b1;
    else list_close = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ce) begin
        if (is_start) begin
          mslot[sel]  = 0;
          mcount[sel] = 0;
        end else begin
          exp_q.push_back({slot_word_addr(sel, 0), 16'h8000});
        end
        break;
      end
    end
    tick();
    list_start = 1'b0;
    list_close = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      tick();
      if (!s_busy) return;
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_writes(input int target);
    for (int t = 0; t < 400; t++) begin
      tick();
      if (n >= target) return;
    end
    chk("write_count_timeout", n, target);
  endtask

  function automatic logic [255:0] rnd_cmd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, {16'd0, s_count}, mcount[sel]);
    chk({tag, "_ovf"}, {31'd0, s_ovf}, {31'd0, mcount[sel] == max_of[sel] - 1});
  endtask

  localparam logic [255:0] CMD1 = {16'hF004, 16'hFFFF, 16'hFFFF, 16'h1234, 16'hFFFF, 16'hFFFF,
                                   16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066,
                                   16'h0077, 16'h0088, 16'h0099, 16'hABCD};

  initial begin
    int b;
    int cyc;
    int held;
    int d0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ready", {31'd0, s_ready}, 32'd1);
    chk("reset_we", {31'd0, s_we}, 32'd0);
    chk("reset_busy", {31'd0, s_busy}, 32'd0);
    chk("reset_done", {31'd0, s_done}, 32'd0);
    chk("reset_a", {14'd0, s_a}, 32'd0);
    chk("reset_d", {16'd0, s_d}, 32'd0);
    chk_status("reset");

    // One command at BASE_LINK 0 with ack tied high: masking, layout, 30-cycle latency
    b = n;
    send_cmd(CMD1);
    cyc = 1;
    while (s_busy && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("cmd_latency", cyc, 30);
    chk("cmd1_writes", n - b, 15);
    chk("cmd1_w0_a", {14'd0, log_a[b]}, 32'h00);
    chk("cmd1_w0_d", {16'd0, log_d[b]}, 32'h0004);
    chk("cmd1_w1_d", {16'd0, log_d[b + 1]}, 32'hFFFC);
    chk("cmd1_w2_a", {14'd0, log_a[b + 2]}, 32'h02);
    chk("cmd1_w2_d", {16'd0, log_d[b + 2]}, 32'h9FFF);
    chk("cmd1_w5_d", {16'd0, log_d[b + 5]}, 32'h3FFF);
    chk("cmd1_w14_a", {14'd0, log_a[b + 14]}, 32'h0E);
    chk("cmd1_w14_d", {16'd0, log_d[b + 14]}, 32'h0099);
    chk_status("cmd1");

    // Rewind, then stall ack for 3 CE cycles on word 5 while CE toggles
    pulse(1'b1);
    tick();
    chk_status("rewind");
    ce_toggle = 1'b1;
    b = n;
    send_cmd(rnd_cmd());
    wait_writes(b + 5);
    ack = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (s_we) break;
    end
    held = 0;
    for (int t = 0; t < 40 && held < 3; t++) begin
      @(negedge clk);
      if (s_we && ce) begin
        chk("stall_a", {14'd0, s_a}, 32'h05);
        held++;
      end
    end
    @(posedge clk);
    #1;
    ack = 1'b1;
    wait_idle();
    ce_toggle = 1'b0;
    tick();
    chk("stall_writes", n - b, 15);
    chk("stall_w5_a", {14'd0, log_a[b + 5]}, 32'h05);
    chk_status("stall");

    // BASE_LINK 0x100: two commands then a terminator, DONE for exactly one cycle
    sel = 1;
    tick();
    b = n;
    send_cmd(rnd_cmd());
    send_cmd(rnd_cmd());
    wait_idle();
    d0 = done_cnt;
    pulse(1'b0);
    wait_idle();
    repeat (3) tick();
    chk("base_slot0_a", {14'd0, log_a[b]}, 32'h400);
    chk("base_slot1_a", {14'd0, log_a[b + 15]}, 32'h410);
    chk("base_term_a", {14'd0, log_a[b + 30]}, 32'h420);
    chk("base_term_d", {16'd0, log_d[b + 30]}, 32'h8000);
    chk("base_writes", n - b, 31);
    chk("base_done_cycles", done_cnt - d0, 1);
    chk_status("base");

    // MAX_CMDS 2: overflow blocks commands, close still allowed, start clears it
    sel = 2;
    tick();
    send_cmd(rnd_cmd());
    wait_idle();
    tick();
    chk_status("ovf");
    chk("ovf_literal", {31'd0, s_ovf}, 32'd1);
    chk("ovf_ready", {31'd0, s_ready}, 32'd0);
    b = n;
    cmd_data  = rnd_cmd();
    cmd_valid = 1'b1;
    repeat (6) tick();
    cmd_valid = 1'b0;
    chk("ovf_ignored_busy", {31'd0, s_busy}, 32'd0);
    chk("ovf_ignored_writes", n - b, 0);
    pulse(1'b0);
    wait_idle();
    tick();
    chk("ovf_term_a", {14'd0, log_a[b]}, 32'h10);
    chk("ovf_term_d", {16'd0, log_d[b]}, 32'h8000);
    pulse(1'b1);
    tick();
    chk_status("ovf_start");
    chk("ovf_start_ready", {31'd0, s_ready}, 32'd1);

    // LIST_START during word 7: command finishes in slot 2, then the list rewinds
    sel = 1;
    tick();
    b = n;
    send_cmd(rnd_cmd());
    wait_writes(b + 7);
    pulse(1'b1);
    wait_idle();
    tick();
    chk("midstart_writes", n - b, 15);
    chk("midstart_last_a", {14'd0, log_a[b + 14]}, 32'h42E);
    chk_status("midstart");
    chk("midstart_ready", {31'd0, s_ready}, 32'd1);
    b = n;
    send_cmd(rnd_cmd());
    wait_idle();
    chk("rewound_a", {14'd0, log_a[b]}, 32'h400);
    chk_status("rewound");

    // Asynchronous reset while word 9 of slot 1 is pending
    b = n;
    send_cmd(rnd_cmd());
    wait_writes(b + 9);
    tick();
    chk("pre_reset_a", {14'd0, s_a}, 32'h419);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_we", {31'd0, s_we}, 32'd0);
    chk("async_reset_count", {16'd0, s_count}, 32'd0);
    chk("async_reset_busy", {31'd0, s_busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      mslot[i]  = 0;
      mcount[i] = 0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    b = n;
    send_cmd(rnd_cmd());
    wait_idle();
    chk("after_reset_a", {14'd0, log_a[b]}, 32'h400);
    chk_status("after_reset");

    tick();
    chk("model_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
